costas_discriminator: RTL and testbench

COSTAS_DISCRIMINATOR -- requirements
Module: costas_discriminator

---
 rtl/costas_discriminator.sv | 136 +++++++++++++
 tb/tb_costas_discriminator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/costas_discriminator.sv
// rtl/costas_discriminator.sv - Costas loop phase discriminator: I/Q integrate-and-dump, then I*Q or sign(I)*Q.
// A two-stage pipeline: the accumulators dump on the final sample of a period, and the discriminator result is registered on the next edge.
module costas_discriminator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_W-1:0]      in_i,
  input  logic signed [IN_W-1:0]      in_q,
  input  logic [LEN_W-1:0]            int_len,
  input  logic [1:0]                  mode,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [2*ACC_W-1:0]   err,
  output logic signed [ACC_W-1:0]     sum_i,
  output logic signed [ACC_W-1:0]     sum_q,
  output logic                        sat,
  output logic                        overrun
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Returns {overflow, saturated sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [IN_W-1:0]  x);
    logic [ACC_W:0] w;
    w = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){x[IN_W-1]}}, x};
    if (w[ACC_W] != w[ACC_W-1])
      sat_add = {1'b1, (w[ACC_W] ? ACC_MIN : ACC_MAX)};
    else
      sat_add = {1'b0, w[ACC_W-1:0]};
  endfunction

  logic signed [ACC_W-1:0]   r_acc_i, r_acc_q;
  logic [LEN_W-1:0]          r_cnt, r_len;
  logic                      r_psat;
  logic signed [ACC_W-1:0]   r_dump_i, r_dump_q;
  logic                      r_dump_sat, r_dump_load;
  logic                      r_out_valid, r_sat, r_overrun;
  logic signed [2*ACC_W-1:0] r_err;
  logic signed [ACC_W-1:0]   r_sum_i, r_sum_q;

  logic signed [ACC_W-1:0]   w_nxt_i, w_nxt_q;
  logic                      w_ovf_i, w_ovf_q;
  logic [LEN_W-1:0]          w_len_now, w_len;
  logic                      w_last;
  logic signed [2*ACC_W-1:0] w_prod, w_ext_i, w_ext_q, w_err_sgn, w_err;
  logic signed [ACC_W-1:0]   w_sel_q;

  always_comb begin
    {w_ovf_i, w_nxt_i} = sat_add(r_acc_i, in_i);
    {w_ovf_q, w_nxt_q} = sat_add(r_acc_q, in_q);
    w_len_now = (int_len == '0) ? LEN_W'(1) : int_len;
    // The period length is captured on its first sample; later int_len changes wait for the next period.
    w_len  = (r_cnt == '0) ? w_len_now : r_len;
    w_last = (r_cnt == w_len - LEN_W'(1));
  end

  always_comb begin
    w_ext_i = {{ACC_W{r_dump_i[ACC_W-1]}}, r_dump_i};
    w_ext_q = {{ACC_W{r_dump_q[ACC_W-1]}}, r_dump_q};
    w_prod  = w_ext_i * w_ext_q;
    if (!r_dump_i[ACC_W-1])
      w_sel_q = r_dump_q;
    else if (r_dump_q == ACC_MIN)
      w_sel_q = ACC_MAX;
    else
      w_sel_q = -r_dump_q;
    w_err_sgn = {{ACC_W{w_sel_q[ACC_W-1]}}, w_sel_q};
    w_err     = (mode == 2'b01) ? w_err_sgn : w_prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_psat      <= 1'b0;
      r_dump_i    <= '0;
      r_dump_q    <= '0;
      r_dump_sat  <= 1'b0;
      r_dump_load <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= '0;
      r_sum_i     <= '0;
      r_sum_q     <= '0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_dump_load <= in_valid && w_last;
      if (in_valid) begin
        if (r_cnt == '0)
          r_len <= w_len_now;
        if (w_last) begin
          r_dump_i   <= w_nxt_i;
          r_dump_q   <= w_nxt_q;
          r_dump_sat <= r_psat | w_ovf_i | w_ovf_q;
          r_acc_i    <= '0;
          r_acc_q    <= '0;
          r_cnt      <= '0;
          r_psat     <= 1'b0;
        end else begin
          r_acc_i <= w_nxt_i;
          r_acc_q <= w_nxt_q;
          r_cnt   <= r_cnt + LEN_W'(1);
          r_psat  <= r_psat | w_ovf_i | w_ovf_q;
        end
      end
      // Newest result always wins; losing an unconsumed one is flagged stickily.
      if (r_dump_load) begin
        r_err       <= w_err;
        r_sum_i     <= r_dump_i;
        r_sum_q     <= r_dump_q;
        r_sat       <= r_dump_sat;
        r_out_valid <= 1'b1;
        if (r_out_valid && !out_ready)
          r_overrun <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign sum_i     = r_sum_i;
  assign sum_q     = r_sum_q;
  assign sat       = r_sat;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_costas_discriminator.sv
// tb/tb_costas_discriminator.sv - Directed checks of costas_discriminator at ACC_W=32 (inst a) and ACC_W=17 (inst b).
module tb_costas_discriminator;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic signed [15:0] in_i, in_q;
  logic [15:0] int_len;
  logic [1:0]  mode;

  logic               a_valid, a_sat, a_ovr;
  logic signed [63:0] a_err;
  logic signed [31:0] a_si, a_sq;
  logic               b_valid, b_sat, b_ovr;
  logic signed [33:0] b_err;
  logic signed [16:0] b_si, b_sq;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  costas_discriminator #(.IN_W(16), .ACC_W(32), .LEN_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .int_len(int_len), .mode(mode), .out_ready(out_ready),
    .out_valid(a_valid), .err(a_err), .sum_i(a_si), .sum_q(a_sq),
    .sat(a_sat), .overrun(a_ovr));

  costas_discriminator #(.IN_W(16), .ACC_W(17), .LEN_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .int_len(int_len), .mode(mode), .out_ready(out_ready),
    .out_valid(b_valid), .err(b_err), .sum_i(b_si), .sum_q(b_sq),
    .sat(b_sat), .overrun(b_ovr));

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at posedge+1; leaves in_valid low after the accepting edge.
  task automatic push(input int i, input int q);
    in_valid = 1'b1;
    in_i = 16'(i);
    in_q = 16'(q);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  int vi [4] = '{2, -4, 7, -300};
  int vq [4] = '{3, 5, -1, 200};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0;
    int_len = 16'd4; mode = 2'b00; out_ready = 1'b0;
    tick();
    check("rst_valid", a_valid, 0);
    check("rst_err", a_err, 0);
    check("rst_ovr", a_ovr, 0);
    rst = 1'b0;
    tick();

    // Mode 00, four samples
    repeat (4) push(100, -50);
    check("m0_latency", a_valid, 0);
    tick();
    check("m0_valid", a_valid, 1);
    check("m0_sum_i", a_si, 400);
    check("m0_sum_q", a_sq, -200);
    check("m0_err", a_err, -80000);
    check("m0_sat", a_sat, 0);
    consume();
    check("m0_consumed", a_valid, 0);

    // Mode 01
    mode = 2'b01;
    repeat (4) push(-3, 7);
    tick();
    check("m1_sum_i", a_si, -12);
    check("m1_sum_q", a_sq, 28);
    check("m1_err", a_err, -28);
    consume();

    // Mode 01 negation of the most negative accumulator value
    int_len = 16'd2;
    repeat (2) push(-1, -32768);
    tick();
    check("m1min_b_sum_q", b_sq, -65536);
    check("m1min_b_err", b_err, 65535);
    check("m1min_a_err", a_err, 65536);
    consume();

    // Saturation on the 17-bit instance
    mode = 2'b00;
    int_len = 16'd4;
    repeat (4) push(32767, 32767);
    tick();
    check("sat_b_sum_i", b_si, 65535);
    check("sat_b_sum_q", b_sq, 65535);
    check("sat_b_flag", b_sat, 1);
    check("sat_b_err", b_err, 64'sd4294836225);
    check("sat_a_sum_i", a_si, 131068);
    check("sat_a_flag", a_sat, 0);
    consume();
    repeat (4) push(1, 2);
    tick();
    check("sat_clr_flag", b_sat, 0);
    check("sat_clr_err", b_err, 32);
    consume();

    // Overrun: two results with no consumer
    int_len = 16'd2;
    push(1, 1); push(1, 1); push(3, 5); push(3, 5);
    check("ovr_first_valid", a_valid, 1);
    check("ovr_first_sum_i", a_si, 2);
    check("ovr_first_flag", a_ovr, 0);
    tick();
    check("ovr_second_sum_i", a_si, 6);
    check("ovr_second_err", a_err, 60);
    check("ovr_set", a_ovr, 1);
    consume();
    check("ovr_drained", a_valid, 0);
    check("ovr_sticky", a_ovr, 1);

    // Gaps, mid-period int_len change, then reset mid-period
    int_len = 16'd3;
    push(10, 1);
    int_len = 16'd5;
    tick();
    push(20, 2);
    tick(); tick();
    push(30, 3);
    check("gap_pending", a_valid, 0);
    tick();
    check("gap_valid", a_valid, 1);
    check("gap_sum_i", a_si, 60);
    check("gap_err", a_err, 360);
    consume();
    int_len = 16'd3;
    push(7, 7); push(7, 7);
    rst = 1'b1;
    #1;
    check("arst_err", a_err, 0);
    check("arst_sum_i", a_si, 0);
    check("arst_ovr", a_ovr, 0);
    check("arst_valid", a_valid, 0);
    tick();
    rst = 1'b0;
    repeat (3) push(1, 2);
    tick();
    check("post_rst_sum_i", a_si, 3);
    check("post_rst_err", a_err, 18);
    consume();

    // One result per accepted sample for int_len 0 and 1
    out_ready = 1'b1;
    for (int len = 0; len < 2; len++) begin
      int_len = 16'(len);
      for (int k = 0; k < 4; k++) begin
        push(vi[k], vq[k]);
        if (k > 0) begin
          check($sformatf("len%0d_valid%0d", len, k - 1), a_valid, 1);
          check($sformatf("len%0d_err%0d", len, k - 1), a_err, vi[k-1] * vq[k-1]);
        end
      end
      tick();
      check($sformatf("len%0d_err3", len), a_err, vi[3] * vq[3]);
      tick();
      check($sformatf("len%0d_idle", len), a_valid, 0);
    end
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
